// File: rtl/sprite_rom_scheduler.sv
// Sprite ROM scheduler: double-buffered per-layer sprite configuration,
// priority hit detection per pixel, shared-ROM address generation and a
// fixed three-stage pipeline from DrawX/DrawY to the pix_* outputs.
module sprite_rom_scheduler #(
  parameter logic [3:0] TRANSPARENT_IDX = 4'd0,
  parameter int         NUM_LAYERS      = 4
) (
  input  logic        pixel_Clk,
  input  logic        Reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        frame_start,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_layer,
  input  logic [2:0]  cfg_field,
  input  logic [17:0] cfg_data,
  input  logic        cfg_commit,
  output logic        commit_pending,
  output logic [17:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic        pix_valid,
  output logic [1:0]  pix_layer,
  output logic [3:0]  pix_index
);

  typedef struct packed {
    logic [17:0] base;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  w;
    logic [9:0]  h;
    logic        en;
  } layer_cfg_t;

  layer_cfg_t stg_q [NUM_LAYERS];
  layer_cfg_t act_q [NUM_LAYERS];

  // A pending request, or one arriving on this very edge, is honoured by frame_start.
  logic do_copy;
  assign do_copy = frame_start & (commit_pending | cfg_commit);

  // Staging writes, staging-to-active copy and commit bookkeeping.
  // Active takes the old staging value when a write lands on the copy edge.
  always_ff @(posedge pixel_Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        stg_q[i] <= '0;
        act_q[i] <= '0;
      end
      commit_pending <= 1'b0;
    end else begin
      if (do_copy) begin
        for (int i = 0; i < NUM_LAYERS; i++) act_q[i] <= stg_q[i];
      end
      if (cfg_we) begin
        case (cfg_field)
          3'd0:    stg_q[cfg_layer].base <= cfg_data;
          3'd1:    stg_q[cfg_layer].x    <= cfg_data[9:0];
          3'd2:    stg_q[cfg_layer].y    <= cfg_data[9:0];
          3'd3:    stg_q[cfg_layer].w    <= cfg_data[9:0];
          3'd4:    stg_q[cfg_layer].h    <= cfg_data[9:0];
          3'd5:    stg_q[cfg_layer].en   <= cfg_data[0];
          default: ;
        endcase
      end
      if (do_copy)         commit_pending <= 1'b0;
      else if (cfg_commit) commit_pending <= 1'b1;
    end
  end

  // Per-layer hit test on the active set; 11-bit end bounds so X+W never wraps.
  logic [NUM_LAYERS-1:0] layer_hit;
  always_comb begin
    layer_hit = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      layer_hit[i] = act_q[i].en
        && (DrawX >= act_q[i].x)
        && ({1'b0, DrawX} < ({1'b0, act_q[i].x} + {1'b0, act_q[i].w}))
        && (DrawY >= act_q[i].y)
        && ({1'b0, DrawY} < ({1'b0, act_q[i].y} + {1'b0, act_q[i].h}));
    end
  end

  // Lowest-index hitting layer wins; only its parameters feed the address.
  logic       win_hit;
  logic [1:0] win_layer;
  always_comb begin
    win_hit   = 1'b0;
    win_layer = 2'd0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_hit[i]) begin
        win_hit   = 1'b1;
        win_layer = 2'(i);
      end
    end
  end

  // Address of the winning layer's texel, wrapped to the 18-bit ROM space.
  layer_cfg_t  win_cfg;
  logic [9:0]  dx, dy;
  logic [17:0] row_off, hit_addr;
  always_comb begin
    win_cfg  = act_q[win_layer];
    dx       = DrawX - win_cfg.x;
    dy       = DrawY - win_cfg.y;
    row_off  = {8'd0, dy} * {8'd0, win_cfg.w};
    hit_addr = win_cfg.base + row_off + {8'd0, dx};
  end

  // Stage 1: register ROM address and the hit/layer tag of this pixel.
  logic       s1_hit, s2_hit;
  logic [1:0] s1_layer, s2_layer;
  always_ff @(posedge pixel_Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      s1_hit   <= 1'b0;
      s1_layer <= 2'd0;
    end else begin
      rom_addr <= win_hit ? hit_addr : 18'd0;
      s1_hit   <= win_hit;
      s1_layer <= win_hit ? win_layer : 2'd0;
    end
  end

  // Stage 2: delay the tag while the ROM produces data for the stage-1 address.
  always_ff @(posedge pixel_Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_hit   <= 1'b0;
      s2_layer <= 2'd0;
    end else begin
      s2_hit   <= s1_hit;
      s2_layer <= s1_layer;
    end
  end

  // Stage 3: combine tag with ROM data; a transparent texel keeps layer/index but is not valid.
  always_ff @(posedge pixel_Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_valid <= 1'b0;
      pix_layer <= 2'd0;
      pix_index <= 4'd0;
    end else begin
      pix_valid <= s2_hit && (rom_data != TRANSPARENT_IDX);
      pix_layer <= s2_hit ? s2_layer : 2'd0;
      pix_index <= s2_hit ? rom_data : 4'd0;
    end
  end

endmodule

// File: tb/tb_sprite_rom_scheduler.sv
// Bench for sprite_rom_scheduler: table-driven pixel vectors with hand-computed
// expectations, a synchronous ROM model, and directed commit/reset sequences.
module tb_sprite_rom_scheduler;

  // ---------------- clock / reset / signals ----------------
  logic        pixel_Clk = 1'b0;
  logic        Reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        frame_start, cfg_we, cfg_commit;
  logic [1:0]  cfg_layer;
  logic [2:0]  cfg_field;
  logic [17:0] cfg_data;
  logic        commit_pending;
  logic [17:0] rom_addr;
  logic [3:0]  rom_data = 4'd0;
  logic        pix_valid;
  logic [1:0]  pix_layer;
  logic [3:0]  pix_index;

  always #5 pixel_Clk = ~pixel_Clk;

  int cyc = 0;
  always @(posedge pixel_Clk) cyc <= cyc + 1;

  sprite_rom_scheduler dut (
    .pixel_Clk      (pixel_Clk),
    .Reset_n        (Reset_n),
    .DrawX          (DrawX),
    .DrawY          (DrawY),
    .frame_start    (frame_start),
    .cfg_we         (cfg_we),
    .cfg_layer      (cfg_layer),
    .cfg_field      (cfg_field),
    .cfg_data       (cfg_data),
    .cfg_commit     (cfg_commit),
    .commit_pending (commit_pending),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .pix_valid      (pix_valid),
    .pix_layer      (pix_layer),
    .pix_index      (pix_index)
  );

  // Synchronous ROM model: data one edge after the address.
  function automatic logic [3:0] rom_fn(input logic [17:0] a);
    if (a == 18'd1890) return 4'd5;
    return a[3:0];
  endfunction
  always @(posedge pixel_Clk) rom_data <= rom_fn(rom_addr);

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int tag   = 0;

  typedef struct { int due; int id; logic [17:0] addr; } addr_exp_t;
  typedef struct { int due; int id; logic v; logic [1:0] l; logic [3:0] idx; } pix_exp_t;
  addr_exp_t addr_q[$];
  pix_exp_t  pix_q[$];

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s #%0d got=%0h want=%0h (t=%0t)", nm, id, act, exp, $time);
    end
  endtask

  // Compare outputs due at this edge; sampled on the falling edge.
  always @(negedge pixel_Clk) begin
    if (Reset_n === 1'b1) begin
      while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
        addr_exp_t a;
        a = addr_q.pop_front();
        if (a.due < cyc) chk("addr_late", a.id, 32'(a.due), 32'(cyc));
        else             chk("rom_addr", a.id, 32'(rom_addr), 32'(a.addr));
      end
      while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
        pix_exp_t p;
        p = pix_q.pop_front();
        if (p.due < cyc) chk("pix_late", p.id, 32'(p.due), 32'(cyc));
        else begin
          chk("pix_valid", p.id, 32'(pix_valid), 32'(p.v));
          chk("pix_layer", p.id, 32'(pix_layer), 32'(p.l));
          chk("pix_index", p.id, 32'(pix_index), 32'(p.idx));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge pixel_Clk);
    #1;
  endtask

  // Present a pixel for the coming edge; optionally schedule its expectations.
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic chk_en,
                     input logic [17:0] a, input logic v, input logic [1:0] l, input logic [3:0] idx);
    addr_exp_t ae;
    pix_exp_t  pe;
    DrawX = x;
    DrawY = y;
    if (chk_en) begin
      tag++;
      ae.due = cyc + 1; ae.id = tag; ae.addr = a;
      pe.due = cyc + 3; pe.id = tag; pe.v = v; pe.l = l; pe.idx = idx;
      addr_q.push_back(ae);
      pix_q.push_back(pe);
    end
  endtask

  task automatic miss(input logic [9:0] x, input logic [9:0] y);
    pix(x, y, 1'b1, 18'd0, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic cfg(input logic [1:0] l, input logic [2:0] f, input logic [17:0] d);
    cfg_we = 1'b1; cfg_layer = l; cfg_field = f; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic set_layer(input logic [1:0] l, input logic [17:0] base, input logic [9:0] x,
                           input logic [9:0] y, input logic [9:0] w, input logic [9:0] h, input logic en);
    cfg(l, 3'd0, base);
    cfg(l, 3'd1, 18'(x));
    cfg(l, 3'd2, 18'(y));
    cfg(l, 3'd3, 18'(w));
    cfg(l, 3'd4, 18'(h));
    cfg(l, 3'd5, 18'(en));
  endtask

  task automatic commit_frame();
    cfg_commit = 1'b1; frame_start = 1'b1;
    tick();
    cfg_commit = 1'b0; frame_start = 1'b0;
  endtask

  task automatic drain();
    repeat (5) tick();
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [9:0]  x, y;
    logic [17:0] addr;
    logic        v;
    logic [1:0]  l;
    logic [3:0]  idx;
  } vec_t;
  vec_t vec_a[12];
  vec_t vec_b[9];

  // ---------------- main sequence ----------------
  initial begin
    Reset_n = 1'b0; DrawX = '0; DrawY = '0; frame_start = 1'b0;
    cfg_we = 1'b0; cfg_layer = '0; cfg_field = '0; cfg_data = '0; cfg_commit = 1'b0;

    // Config A: L0 main sprite, L1 zero width, L2 overlaps L0, L3 wraps the ROM space.
    vec_a[0]  = '{10'd110, 10'd60,  18'd1890, 1'b1, 2'd0, 4'd5};
    vec_a[1]  = '{10'd120, 10'd60,  18'd1900, 1'b1, 2'd0, 4'd12};
    vec_a[2]  = '{10'd187, 10'd60,  18'd1967, 1'b1, 2'd0, 4'd15};
    vec_a[3]  = '{10'd188, 10'd60,  18'd0,    1'b0, 2'd0, 4'd0};
    vec_a[4]  = '{10'd100, 10'd50,  18'd1000, 1'b1, 2'd0, 4'd8};
    vec_a[5]  = '{10'd100, 10'd143, 18'd9184, 1'b0, 2'd0, 4'd0};
    vec_a[6]  = '{10'd100, 10'd144, 18'd0,    1'b0, 2'd0, 4'd0};
    vec_a[7]  = '{10'd99,  10'd60,  18'd0,    1'b0, 2'd0, 4'd0};
    vec_a[8]  = '{10'd0,   10'd0,   18'd0,    1'b0, 2'd0, 4'd0};
    vec_a[9]  = '{10'd130, 10'd70,  18'd2790, 1'b1, 2'd0, 4'd6};
    vec_a[10] = '{10'd502, 10'd500, 18'd1,    1'b1, 2'd3, 4'd1};
    vec_a[11] = '{10'd509, 10'd509, 18'd98,   1'b1, 2'd3, 4'd2};
    // Config B: L0 disabled, L3 at the right screen edge.
    vec_b[0]  = '{10'd120,  10'd60, 18'd44525, 1'b1, 2'd2, 4'd13};
    vec_b[1]  = '{10'd134,  10'd74, 18'd44819, 1'b1, 2'd2, 4'd3};
    vec_b[2]  = '{10'd135,  10'd74, 18'd0,     1'b0, 2'd0, 4'd0};
    vec_b[3]  = '{10'd134,  10'd75, 18'd0,     1'b0, 2'd0, 4'd0};
    vec_b[4]  = '{10'd110,  10'd60, 18'd0,     1'b0, 2'd0, 4'd0};
    vec_b[5]  = '{10'd115,  10'd55, 18'd44420, 1'b1, 2'd2, 4'd4};
    vec_b[6]  = '{10'd127,  10'd55, 18'd44432, 1'b0, 2'd2, 4'd0};
    vec_b[7]  = '{10'd1023, 10'd3,  18'd33,    1'b1, 2'd3, 4'd1};
    vec_b[8]  = '{10'd5,    10'd3,  18'd0,     1'b0, 2'd0, 4'd0};

    // Reset state.
    #3;
    chk("rst_rom_addr",  0, 32'(rom_addr), 0);
    chk("rst_pix_valid", 0, 32'(pix_valid), 0);
    chk("rst_pix_layer", 0, 32'(pix_layer), 0);
    chk("rst_pix_index", 0, 32'(pix_index), 0);
    chk("rst_pending",   0, 32'(commit_pending), 0);
    repeat (3) tick();
    Reset_n = 1'b1;
    tick();

    // Staging only, and a frame_start without commit: still no hit.
    set_layer(2'd0, 18'd1000, 10'd100, 10'd50, 10'd88, 10'd94, 1'b1);
    miss(10'd110, 10'd60); tick();
    frame_start = 1'b1; miss(10'd110, 10'd60); tick();
    frame_start = 1'b0; miss(10'd110, 10'd60); tick();
    chk("nocommit_pending", 0, 32'(commit_pending), 0);

    set_layer(2'd1, 18'd7,      10'd0,   10'd0,   10'd0,  10'd10, 1'b1);
    set_layer(2'd2, 18'd44420,  10'd115, 10'd55,  10'd20, 10'd20, 1'b1);
    set_layer(2'd3, 18'd262143, 10'd500, 10'd500, 10'd10, 10'd10, 1'b1);
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    chk("pending_set", 0, 32'(commit_pending), 1);
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    chk("pending_again", 0, 32'(commit_pending), 1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("pending_clr", 0, 32'(commit_pending), 0);

    for (int i = 0; i < 12; i++) begin
      pix(vec_a[i].x, vec_a[i].y, 1'b1, vec_a[i].addr, vec_a[i].v, vec_a[i].l, vec_a[i].idx);
      tick();
    end
    drain();

    // Uncommitted X write is ignored by frame_start.
    cfg(2'd0, 3'd1, 18'd300);
    frame_start = 1'b1; pix(10'd110, 10'd60, 1'b1, 18'd1890, 1'b1, 2'd0, 4'd5); tick();
    frame_start = 1'b0; pix(10'd110, 10'd60, 1'b1, 18'd1890, 1'b1, 2'd0, 4'd5); tick();
    miss(10'd320, 10'd60); tick();
    // Commit coincident with frame_start applies at once.
    commit_frame();
    chk("same_cycle_pending", 0, 32'(commit_pending), 0);
    pix(10'd320, 10'd60, 1'b1, 18'd1900, 1'b1, 2'd0, 4'd12); tick();
    miss(10'd110, 10'd60); tick();
    // Write on the copy edge: active keeps the pre-write value.
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    frame_start = 1'b1; cfg_we = 1'b1; cfg_layer = 2'd0; cfg_field = 3'd1; cfg_data = 18'd400;
    tick();
    frame_start = 1'b0; cfg_we = 1'b0;
    chk("we_copy_pending", 0, 32'(commit_pending), 0);
    pix(10'd320, 10'd60, 1'b1, 18'd1900, 1'b1, 2'd0, 4'd12); tick();
    miss(10'd420, 10'd60); tick();
    commit_frame();
    pix(10'd420, 10'd60, 1'b1, 18'd1900, 1'b1, 2'd0, 4'd12); tick();
    miss(10'd320, 10'd60); tick();
    drain();

    // Config B; the pixel presented on the copy edge still uses the old set.
    cfg(2'd0, 3'd1, 18'd100);
    cfg(2'd0, 3'd5, 18'd0);
    set_layer(2'd3, 18'd0, 10'd1020, 10'd0, 10'd10, 10'd10, 1'b1);
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    frame_start = 1'b1; pix(10'd420, 10'd60, 1'b1, 18'd1900, 1'b1, 2'd0, 4'd12); tick();
    frame_start = 1'b0; miss(10'd420, 10'd60); tick();
    for (int i = 0; i < 9; i++) begin
      pix(vec_b[i].x, vec_b[i].y, 1'b1, vec_b[i].addr, vec_b[i].v, vec_b[i].l, vec_b[i].idx);
      tick();
    end
    drain();

    // Mid-line reset with a valid pixel on the output and a commit pending.
    cfg(2'd0, 3'd5, 18'd1);
    commit_frame();
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pix(10'd110, 10'd60, 1'b0, 18'd0, 1'b0, 2'd0, 4'd0);
      tick();
    end
    chk("pre_rst_valid",   0, 32'(pix_valid), 1);
    chk("pre_rst_addr",    0, 32'(rom_addr), 1890);
    chk("pre_rst_pending", 0, 32'(commit_pending), 1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("midrst_valid",   0, 32'(pix_valid), 0);
    chk("midrst_addr",    0, 32'(rom_addr), 0);
    chk("midrst_pending", 0, 32'(commit_pending), 0);
    chk("midrst_index",   0, 32'(pix_index), 0);
    tick(); tick();
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      miss(10'd110, 10'd60); tick();
    end
    // Staging was cleared too: committing it changes nothing.
    commit_frame();
    for (int i = 0; i < 2; i++) begin
      miss(10'd110, 10'd60); tick();
    end
    drain();
    set_layer(2'd0, 18'd1000, 10'd100, 10'd50, 10'd88, 10'd94, 1'b1);
    commit_frame();
    pix(10'd110, 10'd60, 1'b1, 18'd1890, 1'b1, 2'd0, 4'd5); tick();
    miss(10'd99, 10'd60); tick();
    drain();

    chk("addr_q_drained", 0, 32'(addr_q.size()), 0);
    chk("pix_q_drained",  0, 32'(pix_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
